// File: rtl/pwm_cap_pkg.sv
// Shared types and constants for the PWM capture block.
// Duty is reported on the same 10-bit, 1/1024 scale as the PWM generator.
package pwm_cap_pkg;

   typedef enum logic {
      ARM     = 1'b0,
      MEASURE = 1'b1
   } state_t;

   localparam int DUTY_W     = 10;
   localparam int DUTY_SCALE = 1024;
   localparam int QUO_W      = 11;
   localparam int DUTY_MAX   = 1023;

   // A 100% high period divides out to exactly 1024, which does not fit in 10 bits.
   function automatic logic [DUTY_W-1:0] clamp_duty(input logic [QUO_W-1:0] q);
      logic [DUTY_W-1:0] r;
      if (q > QUO_W'(DUTY_MAX)) r = DUTY_W'(DUTY_MAX);
      else                      r = q[DUTY_W-1:0];
      return r;
   endfunction

endpackage

// File: rtl/pwm_cap_div.sv
// Restoring divider: quo = num / den, one quotient bit per cycle, QUO_W bits.
// Latency: busy for QUO_W cycles after start; done/quo are valid together in the last busy cycle.
// No backpressure: start is only honoured by the caller while busy is low.
module pwm_cap_div
   import pwm_cap_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [CNT_W+DUTY_W-1:0] num,
   input  logic [CNT_W-1:0]        den,
   output logic                    busy,
   output logic                    done,
   output logic [QUO_W-1:0]        quo
);

   localparam int RW = CNT_W + QUO_W;

   logic [RW-1:0]    rem;
   logic [RW-1:0]    dsh;
   logic [QUO_W-1:0] q;
   logic [3:0]       step;
   logic             ge;
   logic [QUO_W-1:0] q_nxt;

   always_comb begin
      ge    = (rem >= dsh);
      q_nxt = {q[QUO_W-2:0], ge};
   end

   // quo carries the final bit combinationally so the result is usable in the done cycle
   assign done = busy && (step == 4'(QUO_W - 1));
   assign quo  = q_nxt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         busy <= 1'b0;
         step <= '0;
         rem  <= '0;
         dsh  <= '0;
         q    <= '0;
      end else if (start) begin
         busy <= 1'b1;
         step <= '0;
         rem  <= RW'(num);
         dsh  <= {1'b0, den, DUTY_W'(0)};
         q    <= '0;
      end else if (busy) begin
         if (ge) rem <= rem - dsh;
         dsh  <= dsh >> 1;
         q    <= q_nxt;
         step <= step + 4'd1;
         if (done) busy <= 1'b0;
      end
   end

endmodule

// File: rtl/pwm_capture.sv
// PWM period/duty monitor; PWM_CAP_DIR_EN adds latched motor direction and dir_err.
// Latency: valid 12 cycles after the detected rising edge; timeout valid 1 cycle after the counter hits TIMEOUT.
// No backpressure: valid is a one-cycle pulse, edges arriving while the divider is busy drop that capture.
module pwm_capture
   import pwm_cap_pkg::*;
#(
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 100_000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pwm_in,
`ifdef PWM_CAP_DIR_EN
   input  logic [1:0]        dir_in,
`endif
   output logic [DUTY_W-1:0] duty,
   output logic [CNT_W-1:0]  period,
`ifdef PWM_CAP_DIR_EN
   output logic [1:0]        dir,
   output logic              dir_err,
`endif
   output logic              valid,
   output logic              stuck,
   output logic              busy
);

   localparam int            NUM_W = CNT_W + DUTY_W;
   localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);

   logic s1, s2, s3;
   logic rise, edge_any;
   logic [CNT_W-1:0] per_cnt, hi_cnt, edge_cnt, per_cap, hi_plus;
   state_t state_q, state_d;
   logic cap_start, timeout_hit;
   logic div_busy, div_done;
   logic [QUO_W-1:0] div_quo;
   logic [NUM_W-1:0] div_num;
`ifdef PWM_CAP_DIR_EN
   logic [1:0] d1, d2, dir_cap;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         {s1, s2, s3} <= 3'b000;
`ifdef PWM_CAP_DIR_EN
         d1 <= 2'b00;
         d2 <= 2'b00;
`endif
      end else begin
         s1 <= pwm_in;
         s2 <= s1;
         s3 <= s2;
`ifdef PWM_CAP_DIR_EN
         d1 <= dir_in;
         d2 <= d1;
`endif
      end
   end

   assign rise     = s2 & ~s3;
   assign edge_any = s2 ^ s3;

   always_ff @(posedge clk) begin
      if (!rst) state_q <= ARM;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      cap_start   = 1'b0;
      timeout_hit = 1'b0;
      case (state_q)
         ARM: if (rise) state_d = MEASURE;
         MEASURE: begin
            if (edge_cnt == TO) begin
               timeout_hit = 1'b1;
               state_d     = ARM;
            end else if (rise && !div_busy) begin
               cap_start = 1'b1;
            end
         end
         default: state_d = ARM;
      endcase
   end

   // Counters run in both states; a rising edge always restarts the period.
   always_ff @(posedge clk) begin
      if (!rst) begin
         per_cnt  <= '0;
         hi_cnt   <= '0;
         edge_cnt <= '0;
      end else begin
         if (rise) begin
            per_cnt <= CNT_W'(1);
            hi_cnt  <= '0;
         end else begin
            if (per_cnt != '1)     per_cnt <= per_cnt + CNT_W'(1);
            if (s2 && hi_cnt != '1) hi_cnt <= hi_cnt + CNT_W'(1);
         end
         if (edge_any)           edge_cnt <= CNT_W'(1);
         else if (edge_cnt != TO) edge_cnt <= edge_cnt + CNT_W'(1);
      end
   end

   // hi_cnt misses the edge cycle itself, where s is high by definition.
   assign hi_plus = hi_cnt + CNT_W'(1);
   assign div_num = NUM_W'(hi_plus) * NUM_W'(DUTY_SCALE);

   pwm_cap_div #(.CNT_W(CNT_W)) u_div (
      .clk   (clk),
      .rst   (rst),
      .start (cap_start),
      .num   (div_num),
      .den   (per_cnt),
      .busy  (div_busy),
      .done  (div_done),
      .quo   (div_quo)
   );

   assign busy = div_busy;

   always_ff @(posedge clk) begin
      if (!rst) begin
         per_cap <= '0;
`ifdef PWM_CAP_DIR_EN
         dir_cap <= 2'b00;
`endif
      end else if (cap_start) begin
         per_cap <= per_cnt;
`ifdef PWM_CAP_DIR_EN
         dir_cap <= d2;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         valid  <= 1'b0;
         stuck  <= 1'b0;
         duty   <= '0;
         period <= '0;
`ifdef PWM_CAP_DIR_EN
         dir     <= 2'b00;
         dir_err <= 1'b0;
`endif
      end else begin
         valid <= 1'b0;
         if (timeout_hit) begin
            valid  <= 1'b1;
            stuck  <= 1'b1;
            period <= '0;
            duty   <= s2 ? DUTY_W'(DUTY_MAX) : '0;
`ifdef PWM_CAP_DIR_EN
            dir     <= d2;
            dir_err <= &d2;
`endif
         end else begin
            if (rise) stuck <= 1'b0;
            if (div_done && state_q == MEASURE) begin
               valid  <= 1'b1;
               duty   <= clamp_duty(div_quo);
               period <= per_cap;
`ifdef PWM_CAP_DIR_EN
               dir     <= dir_cap;
               dir_err <= &dir_cap;
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: table of steady PWM shapes plus timeout, drop and reset sequences.
module tb_pwm_capture;

   localparam int TO = 4500;

   logic        clk;
   logic        rst;
   logic        pwm_in;
   logic [1:0]  dir_in;
   logic [9:0]  duty;
   logic [31:0] period;
   logic        valid, stuck, busy;
`ifdef PWM_CAP_DIR_EN
   logic [1:0]  dir;
   logic        dir_err;
`endif

   pwm_capture #(.CNT_W(32), .TIMEOUT(TO)) dut (
      .clk     (clk),
      .rst     (rst),
      .pwm_in  (pwm_in),
`ifdef PWM_CAP_DIR_EN
      .dir_in  (dir_in),
`endif
      .duty    (duty),
      .period  (period),
`ifdef PWM_CAP_DIR_EN
      .dir     (dir),
      .dir_err (dir_err),
`endif
      .valid   (valid),
      .stuck   (stuck),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   int valid_cnt = 0;
   int busy_run = 0;
   int last_busy_run = 0;
   int last_cyc = 0;
   longint last_duty = 0;
   longint last_period = 0;
   logic last_stuck = 1'b0;
   logic [1:0] last_dir = 2'b00;
   logic last_err = 1'b0;

   int n_checks = 0;
   int n_err = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (valid) begin
         valid_cnt     <= valid_cnt + 1;
         last_duty     <= longint'(duty);
         last_period   <= longint'(period);
         last_stuck    <= stuck;
         last_cyc      <= cyc;
         last_busy_run <= busy_run;
`ifdef PWM_CAP_DIR_EN
         last_dir      <= dir;
         last_err      <= dir_err;
`endif
      end
      busy_run <= busy ? busy_run + 1 : 0;
   end

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic hold(input logic v, input int n);
      for (int i = 0; i < n; i++) begin
         pwm_in = v;
         @(negedge clk);
      end
   endtask

   task automatic run_pwm(input int per, input int hi, input int n);
      for (int p = 0; p < n; p++)
         for (int i = 0; i < per; i++) begin
            pwm_in = (i < hi);
            @(negedge clk);
         end
   endtask

   typedef struct {
      int         per;
      int         hi;
      int         n;
      logic [1:0] dir_in;
      int         exp_duty;
      int         exp_period;
      int         exp_valids;
      logic       exp_err;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int v0;
      int c;
      vecs[0] = '{4001, 2460, 2, 2'b01,  629, 4001, 1, 1'b0};
      vecs[1] = '{4001, 2343, 2, 2'b01,  599, 4001, 2, 1'b0};
      vecs[2] = '{4001, 4000, 2, 2'b11, 1023, 4001, 2, 1'b1};
      vecs[3] = '{1000,  250, 2, 2'b10,  256, 1000, 2, 1'b0};
      vecs[4] = '{  20,    7, 3, 2'b00,  358,   20, 3, 1'b0};
      vecs[5] = '{  17,   16, 3, 2'b01,  963,   17, 3, 1'b0};
      vecs[6] = '{  25,    1, 3, 2'b10,   40,   25, 3, 1'b0};

      rst = 1'b0;
      pwm_in = 1'b0;
      dir_in = 2'b00;
      repeat (3) @(negedge clk);
      #1;
      check("rst_duty", duty, 0);
      check("rst_period", period, 0);
      check("rst_valid", valid, 0);
      check("rst_stuck", stuck, 0);
      check("rst_busy", busy, 0);
`ifdef PWM_CAP_DIR_EN
      check("rst_dir", dir, 0);
      check("rst_dir_err", dir_err, 0);
`endif
      rst = 1'b1;

      for (int k = 0; k < 7; k++) begin
         v0 = valid_cnt;
         dir_in = vecs[k].dir_in;
         run_pwm(vecs[k].per, vecs[k].hi, vecs[k].n);
         #1;
         check($sformatf("vec%0d_duty", k), last_duty, vecs[k].exp_duty);
         check($sformatf("vec%0d_period", k), last_period, vecs[k].exp_period);
         check($sformatf("vec%0d_valids", k), valid_cnt - v0, vecs[k].exp_valids);
         check($sformatf("vec%0d_busy_len", k), last_busy_run, 11);
         check($sformatf("vec%0d_stuck", k), last_stuck, 0);
`ifdef PWM_CAP_DIR_EN
         check($sformatf("vec%0d_dir", k), last_dir, vecs[k].dir_in);
         check($sformatf("vec%0d_dir_err", k), last_err, vecs[k].exp_err);
`endif
      end

      // held low after activity
      hold(1'b1, 50);
      v0 = valid_cnt;
      pwm_in = 1'b0;
      c = cyc;
      for (int i = 0; i < TO + 20; i++) begin
         @(negedge clk);
         #1;
         if (valid_cnt != v0) break;
      end
      check("to_low_seen", valid_cnt - v0, 1);
      check("to_low_latency", last_cyc - c, TO + 3);
      check("to_low_duty", last_duty, 0);
      check("to_low_period", last_period, 0);
      check("to_low_stuck", last_stuck, 1);
`ifdef PWM_CAP_DIR_EN
      check("to_low_dir", last_dir, 2'b10);
`endif
      hold(1'b0, 20);
      #1;
      check("to_low_single", valid_cnt - v0, 1);
      check("to_low_stuck_hold", stuck, 1);

      // recovery: first rise clears stuck, first valid one full period later
      v0 = valid_cnt;
      c = cyc;
      hold(1'b1, 6);
      #1;
      check("stuck_clear", stuck, 0);
      hold(1'b1, 34);
      hold(1'b0, 60);
      run_pwm(100, 40, 1);
      #1;
      check("recover_valids", valid_cnt - v0, 1);
      check("recover_latency", last_cyc - c, 114);
      check("recover_duty", last_duty, 409);
      check("recover_period", last_period, 100);

      // held high
      v0 = valid_cnt;
      pwm_in = 1'b1;
      c = cyc;
      for (int i = 0; i < TO + 40; i++) begin
         @(negedge clk);
         #1;
         if (stuck) break;
      end
      check("to_high_stuck", stuck, 1);
      check("to_high_latency", last_cyc - c, TO + 3);
      check("to_high_duty", last_duty, 1023);
      check("to_high_period", last_period, 0);
      check("to_high_valids", valid_cnt - v0, 2);

      // shortest reportable period, then a period that drops alternate captures
      hold(1'b0, 5);
      v0 = valid_cnt;
      run_pwm(12, 6, 5);
      hold(1'b0, 20);
      #1;
      check("p12_valids", valid_cnt - v0, 4);
      check("p12_duty", last_duty, 512);
      check("p12_period", last_period, 12);
      check("p12_busy_len", last_busy_run, 11);
      v0 = valid_cnt;
      run_pwm(6, 3, 8);
      hold(1'b0, 20);
      #1;
      check("p6_valids", valid_cnt - v0, 4);
      check("p6_duty", last_duty, 512);
      check("p6_period", last_period, 6);

      // reset while the divider is running
      v0 = valid_cnt;
      pwm_in = 1'b1;
      repeat (6) @(negedge clk);
      #1;
      check("mid_busy", busy, 1);
      rst = 1'b0;
      @(negedge clk);
      #1;
      check("mrst_busy", busy, 0);
      check("mrst_valid", valid, 0);
      check("mrst_duty", duty, 0);
      check("mrst_period", period, 0);
      check("mrst_stuck", stuck, 0);
`ifdef PWM_CAP_DIR_EN
      check("mrst_dir", dir, 0);
      check("mrst_dir_err", dir_err, 0);
`endif
      rst = 1'b1;
      hold(1'b1, 20);
      #1;
      check("mrst_no_valid", valid_cnt - v0, 0);
      hold(1'b0, 5);
      v0 = valid_cnt;
      run_pwm(100, 50, 2);
      #1;
      check("post_rst_valids", valid_cnt - v0, 2);
      check("post_rst_duty", last_duty, 512);
      check("post_rst_period", last_period, 100);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures an incoming PWM waveform, such as the motor drive pin, and reports its period and its duty in the same 10-bit, 1/1024 scale the drive side uses. It is the receive and monitor end of the motor PWM interface. It feeds self-check logic and the debug display so the commanded duty (e.g. 630 or 600) can be confirmed on the actual pin.

## Interface
Parameters:
- CNT_W, 32: width of the period and high-time counters.
- TIMEOUT, 100_000: cycles with no edge after which the input is declared stuck (1 ms at 100 MHz).

Ports (clock and reset first):
- clk  input  1  system clock, 100 MHz.
- rst  input  1  reset, synchronous, active-low.
- pwm_in  input  1  asynchronous PWM input.
- dir_in  input  2  {IN1, IN2} from the motor driver. Present only with PWM_CAP_DIR_EN.
- duty  output  10  measured duty, 0..1023.
- period  output  CNT_W  measured period in clk cycles. 0 when stuck.
- dir  output  2  direction latched with the measurement. Present only with PWM_CAP_DIR_EN.
- dir_err  output  1  dir_in was 2'b11 at capture. Present only with PWM_CAP_DIR_EN.
- valid  output  1  one-cycle pulse when duty, period and dir update.
- stuck  output  1  level. High while no edge has been seen for TIMEOUT cycles.
- busy  output  1  divider running.

## Operation
- pwm_in passes through a 2-flop synchronizer. A third flop detects rising and falling edges on the synchronized signal (s).
- States:
  - ARM: after reset or after a stuck condition, wait for a rising edge of s. No output for a partial period.
  - MEASURE: count cycles since the last rising edge (per_cnt) and cycles with s high (hi_cnt).
  - On each rising edge in MEASURE:
    - capture per_cnt (the period, including the edge cycle) and hi_cnt;
    - reset both counters to 1 and 0;
    - start the divider.
  - On the first rising edge in ARM: only clear the counters and enter MEASURE.
- Divider computes q = (hi*1024)/per as unsigned restoring division, 11 quotient bits, one bit per cycle.
  - hi ≤ per, so q ≤ 1024. duty = min(q, 1023). Truncation, no rounding.
- Edge arriving while the divider is busy: the new period is still measured and the counters restart as normal. That capture is dropped, with no queueing. Minimum reportable period is 12 cycles.
- Timeout: when a counter since the last edge of either polarity reaches TIMEOUT:
  - stuck=1, one valid pulse, period=0;
  - duty=1023 if s is high, 0 if s is low;
  - go to ARM.
- stuck clears on the next rising edge. The first full period after that produces the next valid.
- per_cnt saturates at 2^CNT_W−1. Timeout always fires first, since TIMEOUT < 2^CNT_W.
- A reset mid-divide aborts the division. No valid is issued.

## Timing
- Reset values: duty=0, period=0, valid=0, stuck=0, busy=0, dir=2'b00, dir_err=0. State is ARM.
- The rising edge is detected in cycle E, 2 clocks after the pin is first sampled high. The capture registers load at E.
- busy is high for cycles E+1..E+11. valid pulses at E+12, and duty, period and dir are stable from that cycle until the next update.
- Timeout valid occurs in the cycle after the counter reaches TIMEOUT. stuck rises in the same cycle.
- If a timeout and a divider completion fall in the same cycle, the divider result is dropped and the timeout result is output.
- Outputs hold between valid pulses.

## Configuration
- PWM_CAP_DIR_EN defined:
  - dir_in, dir and dir_err ports exist;
  - dir_in passes through a 2-flop synchronizer and is latched at capture cycle E;
  - dir_err=1 when the latched value is 2'b11;
  - on timeout, dir reports the current synchronized dir_in.
- PWM_CAP_DIR_EN undefined: the ports and the logic are absent. Duty and period behaviour is identical.

## Structure
- pwm_cap_pkg contains:
  - state enum {ARM, MEASURE};
  - DUTY_W=10, DUTY_SCALE=1024, QUO_W=11, DUTY_MAX=1023.
- Sub-module pwm_cap_div is a sequential restoring divider:
  - inputs: start, numerator (hi<<10), denominator;
  - outputs: busy, done, an 11-bit quotient.
- The top level holds the synchronizers, edge detect, counters, timeout, capture registers and clamp.

## Test plan
- 25 kHz PWM, 4001-cycle period, 2460 cycles high (drive duty 630) -> period=4001, duty=629, one valid per period, busy high for 11 cycles before each valid.
- Same period, 2343 cycles high (duty 600) -> duty=599; dir=2'b01 with PWM_CAP_DIR_EN and dir_in=01.
- pwm_in held low after activity -> valid with duty=0, period=0, stuck=1 exactly TIMEOUT+1 cycles after the last edge; held high -> duty=1023, stuck=1. The next rising edge clears stuck, and the first valid comes one full period later.
- 100% high time between rising edges (a 1-cycle low gap, period 4001) -> q=1023 after clamp. A 12-cycle period is captured; a 6-cycle period drops alternate results.
- rst low during busy -> busy=0, no valid, all outputs at reset values. Measurement restarts from ARM.
- dir_in=2'b11 at the edge -> dir_err=1 on the accompanying valid.
